// File: rtl/cbus_arbiter.sv
// Round-robin arbiter merging N CBus masters onto one converter port.
// A grant is held for a whole burst and released after the last beat handshake.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        okay;
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int N = 2,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  cbus_req_t  [N-1:0]      ireqs,
    output cbus_resp_t [N-1:0]      iresps,
    output cbus_req_t               oreq,
    input  cbus_resp_t              oresp,
    output logic                    busy,
    output logic [SEL_W-1:0]        grant
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [4:0]         beats_q, beats_d;

    logic               found;
    logic [SEL_W-1:0]   pick;
    logic [SEL_W-1:0]   cand;

    // First valid master starting at ptr and wrapping modulo N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = SEL_W'((int'(ptr_q) + i) % N);
            if (!found && ireqs[cand].valid) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            beats_q <= beats_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        beats_d = beats_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    beats_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A dropped valid mid-burst does not end the grant; only last does.
                if (oresp.ready) begin
                    beats_d = beats_q + 5'd1;
                    if (oresp.last) begin
                        state_d = IDLE;
                        ptr_d   = (sel_q == SEL_W'(N-1)) ? '0 : sel_q + SEL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state_q == BUSY) begin
            oreq          = ireqs[sel_q];
            iresps[sel_q] = oresp;
        end
    end

    assign busy  = (state_q == BUSY);
    assign grant = sel_q;

endmodule
